// File: rtl/ysyx_22041412_mdu_pkg.sv
// Encodings shared by the RV M-extension multiply/divide unit.
package ysyx_22041412_mdu_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic rs1_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/ysyx_22041412_mdu_div.sv
// Restoring divider on operand magnitudes: one quotient bit per step.
module ysyx_22041412_mdu_div
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            word_i,
  input  logic            div0_i,
  input  logic            ovf_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o
);

  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dsor_q, dsor_d;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  always_comb begin
    quot_d  = quot_q;
    rem_d   = rem_q;
    dsor_d  = dsor_q;
    shifted = {rem_q, quot_q[XLEN-1]};
    diff    = shifted - {1'b0, dsor_q};
    if (load_i) begin
      dsor_d = divisor_i;
      rem_d  = '0;
      // Special cases land the final magnitudes directly; the sign fix-up is shared.
      if (div0_i) begin
        quot_d = '1;
        rem_d  = dividend_i;
      end else if (ovf_i) begin
        quot_d = dividend_i;
      end else if (word_i) begin
        quot_d = dividend_i << (XLEN - 32);
      end else begin
        quot_d = dividend_i;
      end
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = shifted[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_q <= '0;
      rem_q  <= '0;
      dsor_q <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dsor_q <= dsor_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/ysyx_22041412_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiply here, restoring divide in the sub-module.
module ysyx_22041412_mdu
  import ysyx_22041412_mdu_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int HAS_W = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      func3,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam bit W_EN  = (HAS_W != 0) && (XLEN == 64);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;

  logic            load, step;
  logic            is_div, eff_word, s1_signed, s2_signed, s1_neg, s2_neg, div0, ovf;
  logic [XLEN-1:0] op1, op2, mag1, mag2, min_val;
  logic [XLEN-1:0] quot_mag, rem_mag;

  // Request decode: effective operands, magnitudes and the two early-exit divide cases.
  always_comb begin
    is_div    = func3[2];
    eff_word  = W_EN && word && (is_div || func3 == OP_MUL);
    s1_signed = rs1_signed(func3);
    s2_signed = rs2_signed(func3);
    op1       = src1;
    op2       = src2;
    min_val   = {XLEN{1'b1}} << (XLEN - 1);
    if (eff_word) begin
      op1     = s1_signed ? XLEN'(signed'(src1[31:0])) : XLEN'(src1[31:0]);
      op2     = s2_signed ? XLEN'(signed'(src2[31:0])) : XLEN'(src2[31:0]);
      min_val = {XLEN{1'b1}} << 31;
    end
    s1_neg = s1_signed && op1[XLEN-1];
    s2_neg = s2_signed && op2[XLEN-1];
    mag1   = s1_neg ? -op1 : op1;
    mag2   = s2_neg ? -op2 : op2;
    div0   = (op2 == '0);
    ovf    = s1_signed && (op1 == min_val) && (op2 == '1);
  end

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!flush && in_valid) begin
          load = 1'b1;
          if (is_div && (div0 || ovf)) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = eff_word ? CNT_W'(32) : CNT_W'(XLEN);
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          step  = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (flush || out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  always_comb begin
    op_d      = op_q;
    word_d    = word_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    if (load) begin
      op_d      = func3;
      word_d    = eff_word;
      neg_d     = (s1_neg ^ s2_neg) && !(is_div && div0);
      rem_neg_d = s1_neg;
      acc_d     = '0;
      mcand_d   = {{XLEN{1'b0}}, mag1};
      mplier_d  = mag2;
    end else if (step) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  // NOTE: datapath registers are reset too, so the result port reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
    end else begin
      op_q      <= op_d;
      word_q    <= word_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
    end
  end

  ysyx_22041412_mdu_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .step_i    (step),
    .word_i    (eff_word),
    .div0_i    (div0),
    .ovf_i     (ovf),
    .dividend_i(mag1),
    .divisor_i (mag2),
    .quot_o    (quot_mag),
    .rem_o     (rem_mag)
  );

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, rem, res_full;

  always_comb begin
    prod = neg_q ? -acc_q : acc_q;
    quot = neg_q ? -quot_mag : quot_mag;
    rem  = rem_neg_q ? -rem_mag : rem_mag;
    unique case (op_q)
      OP_MUL:                       res_full = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res_full = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res_full = quot;
      default:                      res_full = rem;
    endcase
    result = word_q ? XLEN'(signed'(res_full[31:0])) : res_full;
  end

endmodule

// File: tb/tb_ysyx_22041412_mdu.sv
// Randomised self-checking bench for the multiply/divide unit against an arithmetic model.
module tb_ysyx_22041412_mdu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  func3;
  logic        word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;

  ysyx_22041412_mdu #(.XLEN(64), .HAS_W(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .func3    (func3),
    .word     (word),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain wide/signed arithmetic following the ISA definitions.
  function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       ea, eb, p;
    logic signed [63:0] sa, sb, sq;
    logic signed [31:0] sa32, sb32, sq32;
    logic [31:0]        a32, b32, r32;
    logic [63:0]        r;
    a32 = a[31:0];
    b32 = b[31:0];
    sa32 = a32;
    sb32 = b32;
    sa = a;
    sb = b;
    r32 = '0;
    r = '0;
    if (w && (f3 == 3'd0 || f3[2])) begin
      case (f3)
        3'd0: r32 = a32 * b32;
        3'd4: begin
          if (b32 == 0) r32 = '1;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = a32;
          else begin sq32 = sa32 / sb32; r32 = sq32; end
        end
        3'd5: begin
          if (b32 == 0) r32 = '1;
          else r32 = a32 / b32;
        end
        3'd6: begin
          if (b32 == 0) r32 = a32;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r32 = '0;
          else begin sq32 = sa32 % sb32; r32 = sq32; end
        end
        default: begin
          if (b32 == 0) r32 = a32;
          else r32 = a32 % b32;
        end
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (f3)
      3'd0: r = a * b;
      3'd1: begin ea = {{64{a[63]}}, a}; eb = {{64{b[63]}}, b}; p = ea * eb; r = p[127:64]; end
      3'd2: begin ea = {{64{a[63]}}, a}; eb = {64'd0, b};       p = ea * eb; r = p[127:64]; end
      3'd3: begin ea = {64'd0, a};       eb = {64'd0, b};       p = ea * eb; r = p[127:64]; end
      3'd4: begin
        if (b == 0) r = ONES;
        else if (a == MINV && b == ONES) r = a;
        else begin sq = sa / sb; r = sq; end
      end
      3'd5: begin
        if (b == 0) r = ONES;
        else r = a / b;
      end
      3'd6: begin
        if (b == 0) r = a;
        else if (a == MINV && b == ONES) r = '0;
        else begin sq = sa % sb; r = sq; end
      end
      default: begin
        if (b == 0) r = a;
        else r = a % b;
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic ew;
    ew = w && (f3 == 3'd0 || f3[2]);
    if (f3[2]) begin
      if (ew) begin
        if (b[31:0] == 0) return 1;
        if (!f3[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) return 1;
      end else begin
        if (b == 0) return 1;
        if (!f3[0] && a == MINV && b == ONES) return 1;
      end
    end
    return ew ? 33 : 65;
  endfunction

  function automatic logic [63:0] rnd_operand();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0: v = '0;
      1: v = ONES;
      2: v = MINV;
      3: v = 64'($signed($urandom_range(0, 16)) - 8);
      4: v = 64'hFFFF_FFFF_8000_0000;
      5: v = {{32{1'b0}}, $urandom()};
      default: v = {$urandom(), $urandom()};
    endcase
    return v;
  endfunction

  // Drives a request across one accept edge; returns #1 after that edge.
  task automatic start_op(input logic [2:0] f3, input logic w,
                          input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    func3    = f3;
    word     = w;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    func3    = 3'($urandom());
    src1     = {$urandom(), $urandom()};
    src2     = {$urandom(), $urandom()};
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: out_valid=%b after %0d cycles, required 1", out_valid, lat);
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                       input logic [63:0] b, output logic [63:0] res, output int lat);
    start_op(f3, w, a, b);
    wait_valid(lat);
    res = result;
    consume();
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h, required 0", result); end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    func3    = 3'd5;
    word     = 1'b0;
    src1     = 64'd5;
    src2     = 64'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== ONES) begin
      errors++;
      $display("FAIL first_edge_accept: out_valid=%b result=%h, required 1 %h", out_valid, result, ONES);
    end
    consume();
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t        v[10];
    logic [63:0] res;
    int          lat;
    v[0] = '{3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    v[1] = '{3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    v[2] = '{3'd2, 1'b0, ONES, 64'd2, ONES, 65};
    v[3] = '{3'd4, 1'b0, MINV, ONES, MINV, 1};
    v[4] = '{3'd6, 1'b0, MINV, ONES, 64'd0, 1};
    v[5] = '{3'd5, 1'b0, 64'd5, 64'd0, ONES, 1};
    v[6] = '{3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1};
    v[7] = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, ONES, 33};
    v[8] = '{3'd6, 1'b1, -64'sd7, 64'd2, ONES, 33};
    v[9] = '{3'd1, 1'b1, ONES, ONES, 64'd0, 65};
    for (int i = 0; i < 10; i++) begin
      do_op(v[i].f3, v[i].w, v[i].a, v[i].b, res, lat);
      checks++;
      if (res !== v[i].exp) begin
        errors++;
        $display("FAIL directed_%0d result: got %h, required %h", i, res, v[i].exp);
      end
      checks++;
      if (lat != v[i].lat) begin
        errors++;
        $display("FAIL directed_%0d latency: got %0d, required %0d", i, lat, v[i].lat);
      end
    end
  endtask

  task automatic test_hold();
    logic [63:0] a, b, exp, held;
    int          lat;
    a   = {$urandom(), $urandom()};
    b   = {$urandom(), $urandom()};
    exp = model(3'd3, 1'b0, a, b);
    start_op(3'd3, 1'b0, a, b);
    wait_valid(lat);
    held = result;
    checks++;
    if (held !== exp) begin errors++; $display("FAIL hold_result: got %h, required %h", held, exp); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      func3    = 3'd0;
      src1     = {$urandom(), $urandom()};
      src2     = {$urandom(), $urandom()};
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d: out_valid=%b in_ready=%b result=%h, required 1 0 %h",
                 i, out_valid, in_ready, result, exp);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, b1, a2, b2, exp1, exp2;
    int          lat;
    a1 = {$urandom(), $urandom()};
    b1 = {32'd0, $urandom()} | 64'd1;
    a2 = {$urandom(), $urandom()};
    b2 = {$urandom(), $urandom()};
    exp1 = model(3'd4, 1'b0, a1, b1);
    exp2 = model(3'd0, 1'b0, a2, b2);
    start_op(3'd4, 1'b0, a1, b1);
    in_valid = 1'b1;
    func3    = 3'd0;
    word     = 1'b0;
    src1     = a2;
    src2     = b2;
    wait_valid(lat);
    checks++;
    if (result !== exp1 || lat != 65) begin
      errors++;
      $display("FAIL b2b_first: result=%h lat=%0d, required %h 65", result, lat, exp1);
    end
    consume();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept_in_idle: in_ready=%b, required 0", in_ready);
    end
    wait_valid(lat);
    checks++;
    if (result !== exp2) begin
      errors++;
      $display("FAIL b2b_second: result=%h, required %h", result, exp2);
    end
    consume();
  endtask

  task automatic test_flush();
    logic [63:0] res, exp, a, b;
    int          lat, pulses;
    start_op(3'd0, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL flush_no_pulse: got %0d pulses, required 0", pulses); end
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    exp = model(3'd6, 1'b1, a, b);
    do_op(3'd6, 1'b1, a, b, res, lat);
    checks++;
    if (res !== exp) begin errors++; $display("FAIL flush_recover: got %h, required %h", res, exp); end
  endtask

  task automatic test_reset_busy();
    int pulses;
    start_op(3'd1, 1'b0, {$urandom(), $urandom()}, {$urandom(), $urandom()});
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'd0) begin
      errors++;
      $display("FAIL reset_busy: in_ready=%b out_valid=%b result=%h, required 1 0 0",
               in_ready, out_valid, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (80) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy_quiet: pulses=%0d in_ready=%b, required 0 1", pulses, in_ready);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a, b, res, exp;
    int          lat, elat;
    for (int i = 0; i < 80; i++) begin
      f3   = 3'($urandom_range(0, 7));
      w    = 1'($urandom_range(0, 1));
      a    = rnd_operand();
      b    = rnd_operand();
      exp  = model(f3, w, a, b);
      elat = exp_lat(f3, w, a, b);
      do_op(f3, w, a, b, res, lat);
      checks++;
      if (res !== exp) begin
        errors++;
        $display("FAIL random_%0d f3=%0d w=%0b a=%h b=%h: result %h, required %h", i, f3, w, a, b, res, exp);
      end
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL random_%0d latency: got %0d, required %0d", i, lat, elat);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    func3     = 3'd0;
    word      = 1'b0;
    src1      = '0;
    src2      = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_flush();
    test_reset_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
